// File: rtl/phase_irq_ctrl.sv
// Four-phase instruction sequencer with a prioritised, maskable, vectored interrupt controller.
// Interrupts are sampled once per instruction, on the fetch cycle that completes.
`timescale 1ns/1ps
module phase_irq_ctrl #(
  parameter int unsigned NIRQ       = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter int unsigned VEC_STRIDE = 4,
  localparam int unsigned VW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            mem_ready,
  input  logic            insn_rd,
  input  logic            set_ien,
  input  logic            clear_ien,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic            phase_fetch,
  output logic            phase_decode,
  output logic            phase_exec,
  output logic            phase_rdmem,
  output logic            irq_pend,
  output logic [VW-1:0]   irq_vec,
  output logic [15:0]     isr_addr,
  output logic [NIRQ-1:0] irq_ack,
  output logic            ien,
  output logic [NIRQ-1:0] mask
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StRdmem} state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            ien_q, ien_d;
  logic [NIRQ-1:0] mask_q, mask_d;

  logic            sample;
  logic [NIRQ-1:0] req;
  logic [VW-1:0]   req_vec;

  assign sample = (state_q == StFetch) && mem_ready;
  assign req    = irq & ~mask_q & {NIRQ{ien_q}};

  // Descending scan so the lowest set index wins.
  always_comb begin
    req_vec = vec_q;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) req_vec = VW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    vec_d   = vec_q;
    ien_d   = ien_q;
    mask_d  = mask_we ? mask_wdata : mask_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
          pend_d  = |req;
          vec_d   = req_vec;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = (insn_rd && !pend_q) ? StRdmem : StFetch;
        if (pend_q)         ien_d = 1'b0;
        else if (clear_ien) ien_d = 1'b0;
        else if (set_ien)   ien_d = 1'b1;
      end
      StRdmem: begin
        if (mem_ready) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pend_q  <= 1'b0;
      vec_q   <= '0;
      ien_q   <= 1'b0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vec_q   <= vec_d;
      ien_q   <= ien_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    irq_ack = '0;
    for (int i = 0; i < NIRQ; i++) begin
      irq_ack[i] = (state_q == StExec) && pend_q && (vec_q == VW'(i));
    end
  end

  assign phase_fetch  = (state_q == StFetch);
  assign phase_decode = (state_q == StDecode);
  assign phase_exec   = (state_q == StExec);
  assign phase_rdmem  = (state_q == StRdmem);
  assign irq_pend     = pend_q;
  assign irq_vec      = vec_q;
  assign isr_addr     = VEC_BASE + 16'(vec_q) * 16'(VEC_STRIDE);
  assign ien          = ien_q;
  assign mask         = mask_q;

  // sample is only consumed implicitly through the FETCH branch; kept for readability of intent.
  logic unused_sample;
  assign unused_sample = sample;

endmodule
